// File: rtl/selector_n1_pipe.sv
// selector_n1_pipe: N:1 valid/ready channel selector (fixed or round-robin) with a registered output stage.
// Define SELECTOR_N1_PIPE_PARITY_EN to add a registered even-parity output out_par.
module selector_n1_pipe #(
  parameter int WIDTH = 32,
  parameter int NUM_CH = 4,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        selec,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
`ifdef SELECTOR_N1_PIPE_PARITY_EN
  output logic                    out_par,
`endif
  input  logic                    out_ready
);
  logic [WIDTH-1:0] out_data_q, out_data_d, sel_data;
  logic [SEL_W-1:0] out_chan_q, out_chan_d, ptr_q, ptr_d, rr_grant, grant, idx;
  logic             out_valid_q, out_valid_d, load_en, rr_found, fx_ok, grant_ok, xfer;
  int               tmp;
  always_comb begin
    load_en = !out_valid_q | out_ready;
    rr_grant = '0;
    rr_found = 1'b0;
    tmp = 0;
    idx = '0;
    // Walk offsets from farthest to nearest so the nearest valid channel after ptr wins.
    for (int k = NUM_CH; k >= 1; k--) begin
      tmp = int'(ptr_q) + k;
      tmp = (tmp >= NUM_CH) ? tmp - NUM_CH : tmp;
      idx = SEL_W'(tmp);
      if (in_valid[idx]) begin
        rr_grant = idx;
        rr_found = 1'b1;
      end
    end
    fx_ok = {1'b0, selec} < (SEL_W+1)'(NUM_CH);
    grant = mode ? rr_grant : selec;
    grant_ok = mode ? rr_found : fx_ok;
    in_ready = (grant_ok & load_en & rst_n) ? (NUM_CH'(1) << grant) : '0;
    xfer = |(in_valid & in_ready);
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (in_ready[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    out_valid_d = xfer | (out_valid_q & !load_en);
    out_data_d = xfer ? sel_data : out_data_q;
    out_chan_d = xfer ? grant : out_chan_q;
    ptr_d = (xfer & mode) ? grant : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      ptr_q <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      ptr_q <= ptr_d;
    end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_chan = out_chan_q;
`ifdef SELECTOR_N1_PIPE_PARITY_EN
  logic out_par_q, out_par_d;
  always_comb out_par_d = xfer ? ^sel_data : out_par_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_par_q <= 1'b0;
    else out_par_q <= out_par_d;
  assign out_par = out_par_q;
`endif
endmodule

// File: tb/tb_selector_n1_pipe.sv
// tb_selector_n1_pipe: directed scoreboard bench for selector_n1_pipe (4-channel main DUT, 5-channel range DUT).
module tb_selector_n1_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic         rst_n, mode, out_valid, out_ready;
  logic [127:0] in_data;
  logic [3:0]   in_valid, in_ready;
  logic [1:0]   selec, out_chan;
  logic [31:0]  out_data;
  logic [159:0] in_data5;
  logic [4:0]   in_valid5, in_ready5;
  logic [2:0]   selec5, out_chan5;
  logic [31:0]  out_data5;
  logic         out_valid5;
`ifdef SELECTOR_N1_PIPE_PARITY_EN
  logic         out_par, out_par5;
`endif
  selector_n1_pipe #(.WIDTH(32), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .selec(selec), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
`ifdef SELECTOR_N1_PIPE_PARITY_EN
    .out_par(out_par),
`endif
    .out_ready(out_ready));
  selector_n1_pipe #(.WIDTH(32), .NUM_CH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .mode(1'b0), .selec(selec5), .out_data(out_data5), .out_chan(out_chan5), .out_valid(out_valid5),
`ifdef SELECTOR_N1_PIPE_PARITY_EN
    .out_par(out_par5),
`endif
    .out_ready(1'b1));
  typedef struct packed {logic [31:0] d; logic [1:0] c;} exp_t;
  exp_t        sbq[$];
  int          tests = 0, fails = 0;
  logic [31:0] ch[4];
  logic        mvalid;
  logic [1:0]  mptr;
  int          rr_exp[6] = '{0, 1, 2, 3, 0, 1};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v, input logic ordy);
    logic       le;
    logic [3:0] er;
    int         g, p;
    mode = m; selec = s; in_valid = v; out_ready = ordy;
    in_data = {ch[3], ch[2], ch[1], ch[0]};
    #1;
    le = !mvalid || ordy;
    g = -1;
    p = int'(mptr);
    if (m) begin
      for (int k = 1; k <= 4; k++)
        if (g < 0 && v[(p + k) % 4]) g = (p + k) % 4;
    end else g = int'(s);
    er = (le && g >= 0) ? 4'(1 << g) : 4'b0;
    chk("in_ready", {28'b0, in_ready}, {28'b0, er});
    if (mvalid && ordy) void'(sbq.pop_front());
    if ((er & v) != 4'b0) begin
      sbq.push_back('{ch[g], 2'(g)});
      if (m) mptr = 2'(g);
      mvalid = 1'b1;
    end else if (le) mvalid = 1'b0;
    @(posedge clk); #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, mvalid});
    if (mvalid) begin
      chk("out_data", out_data, sbq[0].d);
      chk("out_chan", {30'b0, out_chan}, {30'b0, sbq[0].c});
`ifdef SELECTOR_N1_PIPE_PARITY_EN
      chk("out_par", {31'b0, out_par}, {31'b0, ^sbq[0].d});
`endif
    end
  endtask
  initial begin
    rst_n = 1'b0; mode = 1'b0; selec = 2'd0; in_valid = 4'hf; out_ready = 1'b1;
    ch = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    in_data = {ch[3], ch[2], ch[1], ch[0]};
    selec5 = 3'd0; in_valid5 = 5'b0; in_data5 = '0;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_chan", {30'b0, out_chan}, 32'd0);
    chk("rst_in_ready", {28'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mvalid = 1'b0; mptr = 2'd3;
    ch[2] = 32'hDEADBEEF;
    step(1'b0, 2'd2, 4'b0100, 1'b1);
    chk("fixed_data", out_data, 32'hDEADBEEF);
    chk("fixed_chan", {30'b0, out_chan}, 32'd2);
    step(1'b0, 2'd2, 4'b0000, 1'b1);
    ch = '{32'h10, 32'h11, 32'h12, 32'h13};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 2'd0, 4'hf, 1'b1);
      chk("rr_seq_chan", {30'b0, out_chan}, 32'(rr_exp[i]));
    end
    ch[1] = 32'h1;
    step(1'b0, 2'd1, 4'b0010, 1'b1);
    ch[1] = 32'h55;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd1, 4'hf, 1'b0);
      chk("stall_data", out_data, 32'h1);
    end
    step(1'b0, 2'd1, 4'b0010, 1'b1);
    chk("resume_data", out_data, 32'h55);
    step(1'b1, 2'd0, 4'hf, 1'b1);
    chk("rr_after_fixed", {30'b0, out_chan}, 32'd2);
    step(1'b1, 2'd0, 4'b0001, 1'b1);
    chk("rr_wrap", {30'b0, out_chan}, 32'd0);
    step(1'b1, 2'd0, 4'b1001, 1'b1);
    chk("rr_skip", {30'b0, out_chan}, 32'd3);
    step(1'b1, 2'd0, 4'b0000, 1'b1);
    ch[0] = 32'h7;
    step(1'b0, 2'd0, 4'b0001, 1'b1);
`ifdef SELECTOR_N1_PIPE_PARITY_EN
    chk("par_7", {31'b0, out_par}, 32'd1);
`endif
    ch[0] = 32'h3;
    step(1'b0, 2'd0, 4'b0001, 1'b1);
`ifdef SELECTOR_N1_PIPE_PARITY_EN
    chk("par_3", {31'b0, out_par}, 32'd0);
`endif
    step(1'b1, 2'd0, 4'hf, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_data", out_data, 32'd0);
    chk("async_rst_in_ready", {28'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mvalid = 1'b0; mptr = 2'd3; sbq.delete();
    step(1'b1, 2'd0, 4'hf, 1'b1);
    chk("rr_restart", {30'b0, out_chan}, 32'd0);
    mode = 1'b0; in_valid = 4'b0;
    in_data5 = {32'hC4C4C4C4, 32'h3, 32'h2, 32'h1, 32'h0};
    in_valid5 = 5'h1f;
    foreach (rr_exp[i]) begin
      if (i > 1) break;
      selec5 = (i == 0) ? 3'd7 : 3'd5;
      #1;
      chk("range_in_ready", {27'b0, in_ready5}, 32'd0);
      @(posedge clk); #1;
      chk("range_out_valid", {31'b0, out_valid5}, 32'd0);
    end
    selec5 = 3'd4;
    #1;
    chk("top_ch_in_ready", {27'b0, in_ready5}, 32'h10);
    @(posedge clk); #1;
    chk("top_ch_valid", {31'b0, out_valid5}, 32'd1);
    chk("top_ch_chan", {29'b0, out_chan5}, 32'd4);
    chk("top_ch_data", out_data5, 32'hC4C4C4C4);
    in_valid5 = 5'b0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
